// File: rtl/store_buffer.sv
// Store buffer between address translation and the data cache: stores are acked at once
// and drained in order, and loads pass through once ordering allows. Option: STBUF_LOAD_BYPASS_EN.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        dc_req,
    output logic [31:0] dc_addr,
    output logic        dc_we,
    output logic [1:0]  dc_size,
    output logic [3:0]  dc_wstrb,
    output logic [31:0] dc_wdata,
    input  logic        dc_addr_ok,
    input  logic        dc_data_ok,
    input  logic [31:0] dc_rdata,
    output logic        empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [31:0]      ent_addr  [DEPTH];
    logic [1:0]       ent_size  [DEPTH];
    logic [3:0]       ent_wstrb [DEPTH];
    logic [31:0]      ent_wdata [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;
    logic             up_pend, st_ack, dn_pend, dn_ld;

    logic load_clear, up_free, ld_resp;
    logic st_accept, ld_issue, ld_accept, drain_req, drain_accept, pop;

`ifdef STBUF_LOAD_BYPASS_EN
    logic addr_hit;
    // Only live entries (head .. head+count-1) can block a load to the same word.
    always_comb begin
        addr_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (((PTR_W+1)'(k) < count) &&
                (ent_addr[head + PTR_W'(k)][31:2] == addr[31:2])) begin
                addr_hit = 1'b1;
            end
        end
    end
    assign load_clear = !dn_pend && !addr_hit;
`else
    assign load_clear = (count == '0) && !dn_pend;
`endif

    // A load's response passes straight through; a drain's response is absorbed here.
    assign ld_resp   = dn_pend && dn_ld && dc_data_ok;
    assign data_ok   = st_ack || ld_resp;
    assign rdata     = ld_resp ? dc_rdata : 32'h0;
    assign up_free   = !up_pend || data_ok;

    // reset gates the combinational paths so outputs idle as soon as reset rises.
    assign st_accept    = !reset && req && we && (count < FULL_CNT) && up_free;
    assign ld_issue     = !reset && req && !we && load_clear && up_free;
    assign ld_accept    = ld_issue && dc_addr_ok;
    assign drain_req    = !reset && (count != '0) && !dn_pend && !ld_issue;
    assign drain_accept = drain_req && dc_addr_ok;
    assign pop          = dn_pend && !dn_ld && dc_data_ok;

    assign addr_ok = st_accept || ld_accept;
    assign dc_req  = ld_issue || drain_req;
    assign empty   = (count == '0) && !dn_pend && !up_pend;

    always_comb begin
        dc_addr  = ent_addr[head];
        dc_we    = 1'b1;
        dc_size  = ent_size[head];
        dc_wstrb = ent_wstrb[head];
        dc_wdata = ent_wdata[head];
        if (ld_issue) begin
            dc_addr  = addr;
            dc_we    = 1'b0;
            dc_size  = size;
            dc_wstrb = 4'h0;
            dc_wdata = 32'h0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            up_pend <= 1'b0;
            st_ack  <= 1'b0;
            dn_pend <= 1'b0;
            dn_ld   <= 1'b0;
        end else begin
            if (st_accept) tail <= tail + PTR_W'(1);
            if (pop)       head <= head + PTR_W'(1);
            case ({st_accept, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            st_ack <= st_accept;
            if (addr_ok)      up_pend <= 1'b1;
            else if (data_ok) up_pend <= 1'b0;
            // New cache accesses only start with dn_pend clear, so set and clear never collide.
            if (ld_accept) begin
                dn_pend <= 1'b1;
                dn_ld   <= 1'b1;
            end else if (drain_accept) begin
                dn_pend <= 1'b1;
                dn_ld   <= 1'b0;
            end else if (dn_pend && dc_data_ok) begin
                dn_pend <= 1'b0;
                dn_ld   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (st_accept) begin
            ent_addr[tail]  <= addr;
            ent_size[tail]  <= size;
            ent_wstrb[tail] <= wstrb;
            ent_wdata[tail] <= wdata;
        end
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between address translation and the data cache on the physical memory port, directly downstream of the load/store unit's memory request interface.
- Stores are acknowledged to the load/store unit at once and held in a FIFO, then drained to the cache in order. Loads pass through to the cache once ordering allows.
- Exceptions are resolved upstream; everything entering this block is committed and non-cancellable.

Parameters:
- DEPTH, 4, number of store entries; power of two, ≥2.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req  in  1  upstream request valid; held until addr_ok
addr  in  32  physical address
we  in  1  1 = store, 0 = load
size  in  2  0 = byte, 1 = half, 2 = word
wstrb  in  4  byte strobes (stores)
wdata  in  32  store data, already lane-replicated
addr_ok  out  1  request accepted this cycle
data_ok  out  1  response for the oldest accepted request
rdata  out  32  load data; valid with data_ok for loads, 0 for stores
dc_req  out  1  cache request valid
dc_addr  out  32  cache address
dc_we  out  1  cache write enable
dc_size  out  2  cache access size
dc_wstrb  out  4  cache strobes
dc_wdata  out  32  cache write data
dc_addr_ok  in  1  cache accepted request
dc_data_ok  in  1  cache response (loads and stores)
dc_rdata  in  32  cache read data
empty  out  1  FIFO empty and no cache access outstanding (used by barriers)

Behaviour:
- Reset (asynchronous):
  - FIFO head/tail pointers and count = 0.
  - up_pend = 0; dn_pend = 0.
  - addr_ok = data_ok = dc_req = 0; empty = 1.
  - Entry payloads are not reset.
- Upstream: at most one accepted-but-unanswered transaction (up_pend).
  - addr_ok may assert in the same cycle data_ok returns the previous transaction.
- Store accept: addr_ok = req & we & (count < DEPTH) & (!up_pend | data_ok).
  - On accept, push {addr, size, wstrb, wdata} at tail.
  - data_ok and rdata = 0 the next cycle.
- Load accept requires all of:
  - req & !we;
  - load_clear (FIFO empty and !dn_pend);
  - (!up_pend | data_ok);
  - dc_addr_ok.
  - The load drives dc_* combinationally from upstream inputs (dc_we = 0); addr_ok = dc_addr_ok.
  - Its data_ok/rdata is dc_data_ok/dc_rdata passed through combinationally.
- Drain:
  - dc_req driven from the head entry (dc_we = 1) when count > 0, !dn_pend and no load is being issued this cycle.
  - The load wins over drain in the same cycle.
  - dc_addr_ok on a drain sets dn_pend; dc_data_ok clears dn_pend and pops the head.
  - A drain's dc_data_ok is never forwarded upstream.
- Downstream: at most one cache access outstanding (dn_pend covers both drain and load); dn_ld marks a load.
- Data_ok sources are mutually exclusive:
  - a buffered-store ack register; or
  - dc_data_ok while dn_ld = 1.
- Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- Full (count = DEPTH): store req stalls with addr_ok = 0; entries keep draining.
- Empty FIFO: dc_req driven only by loads.
- empty = (count == 0) & !dn_pend & !up_pend.
- Reset mid-operation: all in-flight state is dropped; buffered stores are lost (the reset is global).

Optional Feature:
- Macro: STBUF_LOAD_BYPASS_EN.
- Defined: load_clear = !dn_pend & no valid entry matches addr[31:2].
  - Loads to other words may overtake buffered stores.
  - A matching load waits until that entry drains.
  - The load still wins over drain when both are ready.
- Undefined: load_clear = (count == 0) & !dn_pend; the compare logic is not built.

Test Plan:
- Single store: sw 0x1000 = 0xDEADBEEF, wstrb 0xF → addr_ok cycle 0, data_ok cycle 1. dc_req with dc_we = 1, dc_addr 0x1000 follows next cycle; empty returns to 1 after dc_data_ok.
- Fill: 5 back-to-back stores with DEPTH = 4 and cache stalled (dc_addr_ok = 0) → 4 accepted. The 5th holds addr_ok = 0 until the first dc_data_ok pops an entry, then is accepted in the following cycle.
- Ordering: stores to 0x2000 then 0x2004, then load 0x2000 → load dc_req not issued until both stores complete. rdata equals cache data 0x11223344, passed through with data_ok.
- Bypass (macro defined): 2 stores to 0x3000 queued, load 0x4000 → load issued ahead of drain, data_ok before the stores complete. Load 0x3000 → waits until the 0x3000 entries drain.
- Back-to-back: store, load, store with cache always ready → addr_ok and data_ok alternate with no lost or duplicated data_ok. Upstream sees exactly 3 data_ok, in order.
- Reset asserted while count = 3 and dn_pend = 1 → all outputs at reset values that same cycle; empty = 1; no further dc_req.
